// File: rtl/aud_pkg.sv
// Shared definitions for the audio PWM player/capture pair: frame geometry
// defaults, the capture FSM state type and a saturating subtract helper.
package aud_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 8;
  localparam int unsigned DEF_FRAME_LEN   = 257;
  localparam int unsigned DEF_HIGH_OFFSET = 2;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    CAPTURE
  } cap_state_t;

  // a - b, clamped at zero instead of wrapping
  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (a >= b) ? (a - b) : 0;
  endfunction

endpackage

// File: rtl/aud_pwm_sync.sv
// PWM input conditioning: 2-flop synchroniser, optional 3-tap majority
// glitch filter (AUD_PWM_CAPTURE_GLITCH_FILTER_EN) and rising-edge detect.
module aud_pwm_sync (
  input  logic clkd,
  input  logic resetn,
  input  logic i_pwm,
  output logic o_pwm_s,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_pwm_s_d;
  logic w_pwm_s;

  // Two-stage synchroniser for the asynchronous PWM line
  always_ff @(posedge clkd or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pwm;
      r_sync2 <= r_sync1;
    end
  end

`ifdef AUD_PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] r_hist;

  // History of the two previous synchronised bits for the majority vote
  always_ff @(posedge clkd or negedge resetn) begin
    if (!resetn) begin
      r_hist <= 2'b00;
    end else begin
      r_hist <= {r_hist[0], r_sync2};
    end
  end

  // Any two of three agreeing wins, so a lone one-cycle pulse is dropped
  assign w_pwm_s = (r_sync2 & r_hist[0]) | (r_sync2 & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
  assign w_pwm_s = r_sync2;
`endif

  // Delayed copy of the conditioned level for edge detection
  always_ff @(posedge clkd or negedge resetn) begin
    if (!resetn) begin
      r_pwm_s_d <= 1'b0;
    end else begin
      r_pwm_s_d <= w_pwm_s;
    end
  end

  assign o_pwm_s = w_pwm_s;
  assign o_rise  = w_pwm_s & ~r_pwm_s_d;

endmodule

// File: rtl/aud_pwm_capture.sv
// PWM audio demodulator: aligns to the frame-start rising edge, counts high
// cycles over each FRAME_LEN-cycle frame and emits one decoded sample per
// frame on a valid/ready interface. Optional build macro:
// AUD_PWM_CAPTURE_GLITCH_FILTER_EN (majority filter in aud_pwm_sync).
module aud_pwm_capture
  import aud_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned FRAME_LEN   = DEF_FRAME_LEN,
  parameter int unsigned HIGH_OFFSET = DEF_HIGH_OFFSET
) (
  input  logic                  clkd,
  input  logic                  resetn,
  input  logic                  pwm_i,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] sample,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  locked,
  output logic                  overrun,
  output logic [15:0]           frame_count
);

  localparam int unsigned CW         = $clog2(FRAME_LEN + 1);
  localparam int unsigned MAX_SAMPLE = (2 ** DATA_WIDTH) - 1;

  cap_state_t r_state;
  cap_state_t w_state_nxt;

  logic [CW-1:0]         r_period;
  logic [CW-1:0]         r_high;
  logic [CW-1:0]         w_period_nxt;
  logic [CW-1:0]         w_high_nxt;
  logic                  w_frame_done;
  logic [CW-1:0]         w_total;
  logic [31:0]           w_diff;
  logic [DATA_WIDTH-1:0] w_decoded;

  logic                  w_pwm_s;
  logic                  w_rise;
  logic                  w_en_rise;
  logic                  w_load;

  logic [DATA_WIDTH-1:0] r_sample;
  logic                  r_sample_valid;
  logic                  r_overrun;
  logic [15:0]           r_frame_count;
  logic                  r_enable_d;

  aud_pwm_sync u_sync (
    .clkd    (clkd),
    .resetn  (resetn),
    .i_pwm   (pwm_i),
    .o_pwm_s (w_pwm_s),
    .o_rise  (w_rise)
  );

  // Last frame cycle includes the current level in the total
  assign w_total = r_high + CW'(w_pwm_s);
  assign w_diff  = sat_sub(32'(w_total), HIGH_OFFSET);

  // Clamp decoded value to the sample range
  always_comb begin
    w_decoded = '1;
    if (w_diff <= MAX_SAMPLE) begin
      w_decoded = w_diff[DATA_WIDTH-1:0];
    end
  end

  // Next-state and frame counters; disable overrides every state
  always_comb begin
    w_state_nxt  = r_state;
    w_period_nxt = r_period;
    w_high_nxt   = r_high;
    w_frame_done = 1'b0;
    if (!enable) begin
      w_state_nxt  = IDLE;
      w_period_nxt = '0;
      w_high_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt  = ALIGN;
          w_period_nxt = '0;
          w_high_nxt   = '0;
        end
        ALIGN: begin
          // The rise cycle is frame position 0 and is itself high
          if (w_rise) begin
            w_state_nxt  = CAPTURE;
            w_period_nxt = CW'(1);
            w_high_nxt   = CW'(1);
          end
        end
        CAPTURE: begin
          if (r_period == CW'(FRAME_LEN - 1)) begin
            w_frame_done = 1'b1;
            w_period_nxt = '0;
            w_high_nxt   = '0;
          end else begin
            w_period_nxt = r_period + CW'(1);
            w_high_nxt   = r_high + CW'(w_pwm_s);
          end
        end
        default: begin
          w_state_nxt  = IDLE;
          w_period_nxt = '0;
          w_high_nxt   = '0;
        end
      endcase
    end
  end

  // FSM state and frame counters
  always_ff @(posedge clkd or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_period <= '0;
      r_high   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_period <= w_period_nxt;
      r_high   <= w_high_nxt;
    end
  end

  // A finished frame is accepted only if the output slot is free or draining now
  assign w_load    = w_frame_done & (~r_sample_valid | sample_ready);
  assign w_en_rise = enable & ~r_enable_d;

  // Output sample register and valid flag; a new load beats a transfer
  always_ff @(posedge clkd or negedge resetn) begin
    if (!resetn) begin
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
    end else if (w_load) begin
      r_sample       <= w_decoded;
      r_sample_valid <= 1'b1;
    end else if (r_sample_valid && sample_ready) begin
      r_sample_valid <= 1'b0;
    end
  end

  // Sticky overrun and saturating frame count, cleared on a fresh enable
  always_ff @(posedge clkd or negedge resetn) begin
    if (!resetn) begin
      r_overrun     <= 1'b0;
      r_frame_count <= '0;
      r_enable_d    <= 1'b0;
    end else begin
      r_enable_d <= enable;
      if (w_en_rise) begin
        r_overrun     <= 1'b0;
        r_frame_count <= '0;
      end else if (w_frame_done) begin
        if (!w_load) begin
          r_overrun <= 1'b1;
        end
        if (r_frame_count != 16'hFFFF) begin
          r_frame_count <= r_frame_count + 16'd1;
        end
      end
    end
  end

  assign sample       = r_sample;
  assign sample_valid = r_sample_valid;
  assign locked       = (r_state == CAPTURE);
  assign overrun      = r_overrun;
  assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_aud_pwm_capture.sv
// Self-checking bench for aud_pwm_capture: directed frames from the test plan
// followed by randomized frames, compared every cycle against a frame-level model.
module tb_aud_pwm_capture;

  localparam int FL = 257;
  localparam int HO = 2;

  logic        clkd = 1'b0;
  logic        resetn = 1'b0;
  logic        pwm_i = 1'b0;
  logic        enable = 1'b0;
  logic        sample_ready = 1'b0;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        locked;
  logic        overrun;
  logic [15:0] frame_count;

  int total = 0;
  int bad   = 0;

  bit   rand_rdy = 1'b0;
  bit   mid_chk  = 1'b0;
  int   xlog[$];

  // model state
  bit h[4];
  bit s_prev, en_prev;
  int mode;  // 0 idle, 1 waiting for frame start, 2 capturing
  int pos, sum;
  bit m_v, m_ov;
  int m_smp, m_cnt;

  always #5 clkd = ~clkd;

  aud_pwm_capture dut (
    .clkd         (clkd),
    .resetn       (resetn),
    .pwm_i        (pwm_i),
    .enable       (enable),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .locked       (locked),
    .overrun      (overrun),
    .frame_count  (frame_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) h[i] = 1'b0;
    s_prev = 0; en_prev = 0; mode = 0; pos = 0; sum = 0;
    m_v = 0; m_ov = 0; m_smp = 0; m_cnt = 0;
  endfunction

  // conditioned level the design sees this cycle, from the raw input history
  function automatic bit m_level();
`ifdef AUD_PWM_CAPTURE_GLITCH_FILTER_EN
    return (int'(h[1]) + int'(h[2]) + int'(h[3])) >= 2;
`else
    return h[1];
`endif
  endfunction

  function automatic int m_decode(input int t);
    if (t < HO) return 0;
    if (t - HO > 255) return 255;
    return t - HO;
  endfunction

  function automatic void m_step(input bit p, input bit en, input bit rdy);
    bit s, rise, done;
    int t;
    s = m_level();
    rise = s & !s_prev;
    done = 0;
    t = 0;
    if (!en) mode = 0;
    else if (mode == 0) mode = 1;
    else if (mode == 1) begin
      if (rise) begin mode = 2; pos = 1; sum = 1; end
    end else begin
      if (pos == FL - 1) begin
        done = 1; t = sum + int'(s); pos = 0; sum = 0;
      end else begin
        pos++; sum += int'(s);
      end
    end
    if (done) begin
      if (!m_v || rdy) begin m_smp = m_decode(t); m_v = 1; end
      else m_ov = 1;
      if (m_cnt < 65535) m_cnt++;
    end else if (m_v && rdy) m_v = 0;
    if (en && !en_prev) begin m_ov = 0; m_cnt = 0; end
    en_prev = en;
    s_prev = s;
    h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = p;
  endfunction

  // Compare on the falling edge, then advance the model with the inputs the next edge sees
  always @(negedge clkd) begin
    if (!resetn) m_reset();
    chk("sample", sample, m_smp);
    chk("sample_valid", sample_valid, m_v);
    chk("locked", locked, mode == 2);
    chk("overrun", overrun, m_ov);
    chk("frame_count", frame_count, m_cnt);
    if (sample_valid === 1'b1 && sample_ready === 1'b1) xlog.push_back(int'(sample));
    if (resetn) m_step(pwm_i, enable, sample_ready);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clkd); #1;
      pwm_i = 1'b0;
    end
  endtask

  // One PWM frame: hi high cycles from position 0, optional inverted cycle at g,
  // ready forced to rv at position rp, enable dropped at position ep
  task automatic frame(input int hi, input int g, input int rp, input bit rv, input int ep);
    for (int p = 0; p < FL; p++) begin
      @(posedge clkd); #1;
      pwm_i = (p < hi) ^ (p == g);
      if (p == rp) sample_ready = rv;
      if (p == ep) enable = 1'b0;
      if (rand_rdy) sample_ready = 1'($urandom_range(0, 1));
      if (mid_chk && p == 5) begin
        chk("t3_hold_sample", sample, 32'h10);
        chk("t3_hold_valid", sample_valid, 1);
        chk("t3_overrun", overrun, 1);
      end
    end
  endtask

  initial begin
    int exp_x[11];
    int hi, g, ep;
    m_reset();
    repeat (3) @(posedge clkd);
    #1;
    resetn = 1'b1;
    enable = 1'b1;
    sample_ready = 1'b1;
    idle(6);

    // 1: mid-scale frames
    repeat (3) frame(130, -1, -1, 1'b0, -1);
    chk("t1_locked", locked, 1);
    chk("t1_frame_count", frame_count, 2);

    // 2: boundary high times
    frame(2, -1, -1, 1'b0, -1);
    frame(257, -1, -1, 1'b0, -1);
    frame(1, -1, -1, 1'b0, -1);

    // 3: back-pressure and overrun
    frame(18, -1, 10, 1'b0, -1);
    frame(34, -1, -1, 1'b0, -1);
    mid_chk = 1'b1;
    frame(50, -1, 10, 1'b1, -1);
    mid_chk = 1'b0;

    // 4: disable mid-frame and realign
    frame(66, -1, -1, 1'b0, 100);
    chk("t4_unlocked", locked, 0);
    idle(5);
    enable = 1'b1;
    idle(5);
    chk("t4_overrun_clr", overrun, 0);
    chk("t4_count_clr", frame_count, 0);
    frame(82, -1, -1, 1'b0, -1);

    // 5: asynchronous reset with a pending sample
    frame(98, -1, 10, 1'b0, -1);
    idle(20);
    chk("t5_pending_valid", sample_valid, 1);
    chk("t5_pending_sample", sample, 32'h60);
    @(posedge clkd); #3;
    resetn = 1'b0;
    #1;
    chk("t5_rst_sample", sample, 0);
    chk("t5_rst_valid", sample_valid, 0);
    chk("t5_rst_overrun", overrun, 0);
    chk("t5_rst_count", frame_count, 0);
    chk("t5_rst_locked", locked, 0);
    repeat (2) @(posedge clkd);
    #1;
    resetn = 1'b1;
    sample_ready = 1'b1;
    idle(6);
    frame(114, -1, -1, 1'b0, -1);

    // 6: single low glitch inside a high run
    frame(130, 60, -1, 1'b0, -1);

    // randomized frames, glitches, back-pressure and enable drops
    rand_rdy = 1'b1;
    for (int f = 0; f < 14; f++) begin
      hi = $urandom_range(0, 257);
      g  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 256) : -1;
      ep = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 256) : -1;
      frame(hi, g, -1, 1'b0, ep);
      if (!enable) begin
        idle(4);
        enable = 1'b1;
      end
    end
    rand_rdy = 1'b0;
    sample_ready = 1'b1;
    idle(FL + 10);

    exp_x = '{32'h80, 32'h80, 32'h80, 32'h00, 32'hFF, 32'h00, 32'h10, 32'h30, 32'h50, 32'h70,
`ifdef AUD_PWM_CAPTURE_GLITCH_FILTER_EN
              32'h80};
`else
              32'h7F};
`endif
    chk("xfer_log_len", xlog.size() >= 11, 1);
    for (int i = 0; i < 11; i++) begin
      if (i < xlog.size()) chk($sformatf("xfer[%0d]", i), xlog[i], exp_x[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aud_pwm_capture.md
Name: aud_pwm_capture

Overview:
PWM audio demodulator. It is the receive end of the audio PWM player: it samples an incoming 1-bit PWM stream on clkd and aligns to the frame start. It measures high time per frame and reconstructs one DATA_WIDTH-bit sample per frame. Samples are delivered over a valid/ready interface to a sample buffer or bus-side FIFO (loopback test, line capture).

Parameters:
- DATA_WIDTH, 8, sample width.
- FRAME_LEN, 257, clkd cycles per PWM frame: one READ cycle plus 2^DATA_WIDTH PLAY cycles of the player.
- HIGH_OFFSET, 2, fixed high cycles the player emits beyond the duty value; subtracted from the measured high time.

Ports:
- clkd  in  1  sample clock, same divided clock as the player.
- resetn  in  1  reset.
- pwm_i  in  1  asynchronous PWM input.
- enable  in  1  capture enable, level.
- sample  out  DATA_WIDTH  decoded sample.
- sample_valid  out  1  sample is valid.
- sample_ready  in  1  consumer accepts sample.
- locked  out  1  aligned to the frame and capturing.
- overrun  out  1  sticky; a frame completed while the previous sample was still pending.
- frame_count  out  16  completed frames, saturating.

Behaviour:
- Reset is resetn, asynchronous, active-low. The clock is clkd.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - synchroniser flops 0;
  - period and high counters 0.
- Input path: 2-flop synchroniser produces pwm_s. Edge detect: rise = pwm_s & ~pwm_s_d, where pwm_s_d is pwm_s delayed one cycle.
- State IDLE:
  - locked=0, counters cleared.
  - enable=1 -> ALIGN next cycle.
- State ALIGN:
  - Waits for rise.
  - On rise, the current cycle is frame position 0: period=1 and high=1 next cycle; go to CAPTURE; locked=1.
  - No timeout.
- State CAPTURE: each cycle, period+=1 and high+=pwm_s.
  - The frame spans FRAME_LEN consecutive cycles starting at the rise cycle.
  - On the last frame cycle (period==FRAME_LEN-1): total = high + pwm_s, then period<=0 and high<=0. The next cycle is position 0 of the following frame.
  - Frame timing is free-running after alignment. Rising edges inside a frame are not re-aligned.
- Arithmetic:
  - Counter width is $clog2(FRAME_LEN+1).
  - If total < HIGH_OFFSET, the decoded value is 0.
  - If total-HIGH_OFFSET > 2^DATA_WIDTH-1, it saturates to all-ones.
  - Otherwise the decoded value is total-HIGH_OFFSET.
- Output handshake:
  - On the last frame cycle, if sample_valid=0 or sample_ready=1 in that same cycle: sample <= decoded and sample_valid <= 1. sample_valid is asserted on the cycle after the last frame cycle.
  - Otherwise the new value is dropped and overrun <= 1. The old sample is held.
  - Transfer occurs when sample_valid & sample_ready. sample_valid then clears unless a new sample loads in the same cycle; a new load wins.
  - sample is stable while valid & ~ready.
- frame_count increments on every completed frame, including dropped ones, and saturates at 0xFFFF.
- overrun and frame_count clear only on reset or on an enable 0->1 transition.
- enable=0 in any state:
  - next cycle IDLE, locked=0, partial frame discarded with no sample produced;
  - a pending sample_valid remains until accepted.
- Reset mid-frame aborts immediately to reset values.
- Latency: pwm_i to pwm_s is 2 cycles. The sample appears 1 cycle after the frame's last cycle.

Optional Feature:
AUD_PWM_CAPTURE_GLITCH_FILTER_EN
- Defined: 3-tap majority filter after the synchroniser. pwm_s is the majority of the last 3 synchronised bits. Single-cycle glitches are rejected. Input latency rises from 2 to 3 cycles and the filter resets to 0.
- Undefined: pwm_s is the raw synchroniser output.

Decomposition:
- Package aud_pkg:
  - DATA_WIDTH, FRAME_LEN and HIGH_OFFSET defaults, shared with the player;
  - cap_state_t enum {IDLE, ALIGN, CAPTURE};
  - saturating-subtract function.
- One sub-module, aud_pwm_sync: 2-flop synchroniser, optional majority filter, rise output.
- The top holds the FSM, counters, output register and flags.

Test Plan:
1. Enable=1. Per frame, drive rise then pwm_i high 130 cycles, low 127 cycles (257 total), ready=1 -> locked=1, sample=0x80 each frame, frame_count increments by 1 per frame.
2. Frames with high times 2 and 257 (the constant-high frame is entered from a low cycle) -> samples 0x00 and 0xFF (saturated). High time 1 -> 0x00.
3. ready=0 across 2 frames with values 0x10 then 0x20 -> sample holds 0x10, overrun=1. Raise ready -> 0x10 transfers once; next frame 0x30 delivered.
4. enable->0 at frame position 100 -> no sample, IDLE, locked=0. enable->1 -> realigns on the next rise, overrun/frame_count cleared, first sample correct.
5. resetn asserted mid-frame with sample_valid=1 -> all outputs 0 asynchronously. Release -> IDLE, normal capture resumes.
6. With AUD_PWM_CAPTURE_GLITCH_FILTER_EN: 1-cycle low glitch inside a 130-cycle high run -> sample still 0x80. Without the macro -> 0x7F.
